reg_file_write_decoder: RTL and testbench

//   Write side of the 32-entry register file. Decodes a 5-bit write select to one-hot
//   and updates the addressed 32-bit register under byte enables. Exposes every

---
 rtl/reg_file_write_decoder.sv | 86 ++++++++
 tb/tb_reg_file_write_decoder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_write_decoder.sv
// rtl/reg_file_write_decoder.sv - 32-entry register file write side with byte enables, ack and saturating write count
// Optional REG0_ZERO_EN: Reg0 hardwired to zero and writes to select 0 discarded.
module reg_file_write_decoder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                   Clk,
  input  logic                                   Reset,
  input  logic                                   WriteEn,
  input  logic [ADDR_WIDTH-1:0]                  WriteSelect,
  input  logic [DATA_WIDTH-1:0]                  WriteData,
  input  logic [DATA_WIDTH/8-1:0]                ByteEn,
  output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]  RegBus,
  output logic                                   WriteAck,
  output logic [CNT_WIDTH-1:0]                   WriteCount
);

  localparam int NUM_REGS  = 2**ADDR_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH/8;

`ifdef REG0_ZERO_EN
  localparam bit REG0_IS_ZERO = 1'b1;
`else
  localparam bit REG0_IS_ZERO = 1'b0;
`endif

  logic [NUM_REGS-1:0] sel_onehot;
  logic                sel_blocked;
  logic                write_accept;

  always_comb begin
    sel_onehot              = '0;
    sel_onehot[WriteSelect] = 1'b1;
  end

  // A discarded Reg0 write must not ack or count, so the block folds into acceptance.
  assign sel_blocked  = REG0_IS_ZERO && (WriteSelect == '0);
  assign write_accept = WriteEn && (|ByteEn) && !sel_blocked;

  genvar k;
  generate
    for (k = 0; k < NUM_REGS; k++) begin : g_reg
      logic [DATA_WIDTH-1:0] reg_q;
      logic [NUM_BYTES-1:0]  byte_we;

      assign byte_we = {NUM_BYTES{write_accept & sel_onehot[k]}} & ByteEn;

      if (REG0_IS_ZERO && (k == 0)) begin : g_zero
        assign reg_q = '0;
      end else begin : g_flop
        always_ff @(posedge Clk or posedge Reset) begin
          if (Reset) begin
            reg_q <= '0;
          end else begin
            for (int b = 0; b < NUM_BYTES; b++) begin
              if (byte_we[b]) begin
                reg_q[8*b +: 8] <= WriteData[8*b +: 8];
              end
            end
          end
        end
      end

      assign RegBus[k*DATA_WIDTH +: DATA_WIDTH] = reg_q;
    end
  endgenerate

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      WriteAck <= 1'b0;
    end else begin
      WriteAck <= write_accept;
    end
  end

  // Saturates at all-ones instead of wrapping.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      WriteCount <= '0;
    end else if (write_accept && (WriteCount != {CNT_WIDTH{1'b1}})) begin
      WriteCount <= WriteCount + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_reg_file_write_decoder.sv
// tb/tb_reg_file_write_decoder.sv - self-checking bench for reg_file_write_decoder
module tb_reg_file_write_decoder;

  logic          Clk;
  logic          Reset;
  logic          WriteEn;
  logic [4:0]    WriteSelect;
  logic [31:0]   WriteData;
  logic [3:0]    ByteEn;
  logic [1023:0] RegBus;
  logic          WriteAck;
  logic [15:0]   WriteCount;
  logic [1023:0] regbus_s;
  logic          ack_s;
  logic [1:0]    cnt_s;

  int total = 0;
  int bad   = 0;
  bit check_en = 0;

  logic [31:0] m_regs [32];
  logic        m_ack;
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt_s;

  reg_file_write_decoder dut (
    .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .WriteSelect(WriteSelect),
    .WriteData(WriteData), .ByteEn(ByteEn), .RegBus(RegBus),
    .WriteAck(WriteAck), .WriteCount(WriteCount)
  );

  reg_file_write_decoder #(.CNT_WIDTH(2)) dut_s (
    .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .WriteSelect(WriteSelect),
    .WriteData(WriteData), .ByteEn(ByteEn), .RegBus(regbus_s),
    .WriteAck(ack_s), .WriteCount(cnt_s)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] slice(input int k);
    return RegBus[k*32 +: 32];
  endfunction

  // Reference model: register array plus ack/count from the acceptance rule.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
      m_ack   = 1'b0;
      m_cnt   = 16'h0;
      m_cnt_s = 2'd0;
    end else begin
      bit acc;
      acc = WriteEn && (ByteEn != 4'h0);
`ifdef REG0_ZERO_EN
      if (WriteSelect == 5'd0) acc = 1'b0;
`endif
      if (acc) begin
        for (int b = 0; b < 4; b++)
          if (ByteEn[b]) m_regs[WriteSelect][8*b +: 8] = WriteData[8*b +: 8];
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (m_cnt_s != 2'd3) m_cnt_s = m_cnt_s + 2'd1;
      end
      m_ack = acc;
    end
  end

  always @(negedge Clk) begin
    if (check_en) begin
      for (int k = 0; k < 32; k++) chk($sformatf("cyc_reg%0d", k), slice(k), m_regs[k]);
      chk("cyc_ack", {31'b0, WriteAck}, {31'b0, m_ack});
      chk("cyc_cnt", {16'b0, WriteCount}, {16'b0, m_cnt});
      chk("cyc_ack_s", {31'b0, ack_s}, {31'b0, m_ack});
      chk("cyc_cnt_s", {30'b0, cnt_s}, {30'b0, m_cnt_s});
      chk("cyc_bus_s", {31'b0, (regbus_s == RegBus)}, 32'd1);
    end
  end

  task automatic write(input logic [4:0] sel, input logic [31:0] d, input logic [3:0] be);
    WriteEn = 1'b1; WriteSelect = sel; WriteData = d; ByteEn = be;
    @(posedge Clk); #1;
    WriteEn = 1'b0; ByteEn = 4'h0;
  endtask

  initial begin
    int ack_ones;
    logic [31:0] d;
    Reset = 1'b1; WriteEn = 1'b0; WriteSelect = '0; WriteData = '0; ByteEn = '0;
    repeat (2) @(posedge Clk); #1;
    chk("rst_ack", {31'b0, WriteAck}, 32'd0);
    chk("rst_cnt", {16'b0, WriteCount}, 32'd0);
    for (int k = 0; k < 32; k++) chk($sformatf("rst_reg%0d", k), slice(k), 32'h0);
    Reset = 1'b0;
    check_en = 1;

    write(5'h1F, 32'hDEADBEEF, 4'hF);
    chk("t2_reg31", slice(31), 32'hDEADBEEF);
    chk("t2_ack", {31'b0, WriteAck}, 32'd1);
    chk("t2_cnt", {16'b0, WriteCount}, 32'd1);
    chk("t2_reg30", slice(30), 32'h0);

    write(5'd3, 32'h11223344, 4'hF);
    write(5'd3, 32'hAABBCCDD, 4'b0101);
    chk("t3_merge", slice(3), 32'h11BB33DD);
    write(5'd3, 32'hFFFFFFFF, 4'h0);
    chk("t3_be0_reg", slice(3), 32'h11BB33DD);
    chk("t3_be0_ack", {31'b0, WriteAck}, 32'd0);
    chk("t3_be0_cnt", {16'b0, WriteCount}, 32'd3);

    write(5'd0, 32'h12345678, 4'hF);
`ifdef REG0_ZERO_EN
    chk("t4_reg0", slice(0), 32'h0);
    chk("t4_ack", {31'b0, WriteAck}, 32'd0);
    chk("t4_cnt", {16'b0, WriteCount}, 32'd3);
`else
    chk("t4_reg0", slice(0), 32'h12345678);
    chk("t4_ack", {31'b0, WriteAck}, 32'd1);
    chk("t4_cnt", {16'b0, WriteCount}, 32'd4);
`endif

    // Reset in the middle of a cycle with a write pending.
    WriteEn = 1'b1; WriteSelect = 5'd7; WriteData = 32'h77777777; ByteEn = 4'hF;
    @(posedge Clk); #1;
    WriteSelect = 5'd8; WriteData = 32'h88888888;
    #2 Reset = 1'b1;
    #1;
    chk("mid_ack", {31'b0, WriteAck}, 32'd0);
    chk("mid_cnt", {16'b0, WriteCount}, 32'd0);
    chk("mid_reg7", slice(7), 32'h0);
    chk("mid_reg31", slice(31), 32'h0);
    WriteEn = 1'b0; ByteEn = 4'h0;
    @(negedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    chk("mid_reg8_lost", slice(8), 32'h0);

    ack_ones = 0;
    for (int k = 0; k < 32; k++) begin
      d = 32'(k) * 32'h01010101;
      WriteEn = 1'b1; WriteSelect = 5'(k); WriteData = d; ByteEn = 4'hF;
      @(posedge Clk); #1;
      if (WriteAck) ack_ones++;
    end
    WriteEn = 1'b0; ByteEn = 4'h0;
`ifdef REG0_ZERO_EN
    chk("t5_ack_run", ack_ones, 32'd31);
    chk("t5_cnt", {16'b0, WriteCount}, 32'd31);
`else
    chk("t5_ack_run", ack_ones, 32'd32);
    chk("t5_cnt", {16'b0, WriteCount}, 32'd32);
`endif
    for (int k = 0; k < 32; k++) begin
      d = 32'(k) * 32'h01010101;
      chk($sformatf("t5_read%0d", k), slice(k), d);
    end
    chk("t5_reg31", slice(31), 32'h1F1F1F1F);
    @(posedge Clk); #1;
    chk("t5_ack_drop", {31'b0, WriteAck}, 32'd0);

    chk("t6_sat_pre", {30'b0, cnt_s}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      write(5'd9, 32'h0000_0100 + 32'(i), 4'h1);
      chk("t6_ack_s", {31'b0, ack_s}, 32'd1);
      chk("t6_cnt_s", {30'b0, cnt_s}, 32'd3);
    end
    chk("t6_reg9", slice(9), 32'h09090902);

    repeat (2) @(posedge Clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
